// File: rtl/frame_gen_and_check_pkg.sv
// Shared widths, generator states and the beat-pattern helpers used by both
// the frame generator and the frame checker.
package frame_gen_and_check_pkg;

    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int LANES  = 8;
    localparam int LEN_W  = 14;

    typedef enum logic {
        GEN_SEND,
        GEN_IDLE
    } gen_state_e;

    function automatic logic [31:0] beat_word(input logic [15:0] seq,
                                              input logic [7:0]  beat,
                                              input logic [7:0]  lane);
        return {seq, beat, lane};
    endfunction

    function automatic logic [DATA_W-1:0] beat_data(input logic [15:0] seq,
                                                    input logic [7:0]  beat);
        logic [DATA_W-1:0] data;
        data = '0;
        for (int i = 0; i < LANES; i++) begin
            data[32*i +: 32] = beat_word(seq, beat, 8'(i));
        end
        return data;
    endfunction

    function automatic logic [KEEP_W-1:0] expected_keep(input logic [7:0]        beat,
                                                        input logic [7:0]        last_beat,
                                                        input logic [KEEP_W-1:0] last_keep);
        return (beat == last_beat) ? last_keep : '1;
    endfunction

    function automatic int keep_popcount(input logic [KEEP_W-1:0] keep);
        int count;
        count = 0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) count++;
        end
        return count;
    endfunction

endpackage

// File: rtl/frame_gen_and_check_if.sv
// 256-bit AXI-Stream bundle with routing tuser fields; master drives the beat,
// slave drives tready.
interface frame_gen_and_check_if;
    import frame_gen_and_check_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [LEN_W-1:0]  tuser_packet_length;
    logic [2:0]        tuser_in_port;
    logic [7:0]        tuser_out_port;
    logic [2:0]        tuser_in_vport;
    logic [7:0]        tuser_out_vport;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
               tuser_in_vport, tuser_out_vport, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
               tuser_in_vport, tuser_out_vport, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/frame_gen_and_check_checker.sv
// Receive side: tracks the expected seq/beat, flags bad beats and keeps a
// saturating error count. Define FRAME_GEN_TUSER_CHECK_EN to also check tuser.
module frame_checker
    import frame_gen_and_check_pkg::*;
#(
    parameter int               FRAME_BEATS = 4,
    parameter logic [KEEP_W-1:0] LAST_KEEP  = '1,
    parameter logic [2:0]       IN_PORT     = 3'd0,
    parameter logic [7:0]       OUT_PORT    = 8'h01,
    parameter logic [LEN_W-1:0] PACKET_LEN  = 14'd128
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_gen_and_check_if.slave  s_axis,
    output logic [7:0]            error_count
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_BEATS - 1);

    logic [15:0]       rx_seq_q, rx_seq_d;
    logic [7:0]        rx_beat_q, rx_beat_d;
    logic [7:0]        err_q, err_d;
    logic              ready_q;
    logic              accept;
    logic              bad;
    logic              tuser_bad;
    logic [DATA_W-1:0] exp_data;
    logic [KEEP_W-1:0] exp_keep;
    logic              exp_last;

`ifdef FRAME_GEN_TUSER_CHECK_EN
    assign tuser_bad = (s_axis.tuser_packet_length != PACKET_LEN) ||
                       (s_axis.tuser_in_port       != IN_PORT)    ||
                       (s_axis.tuser_in_vport      != IN_PORT)    ||
                       (s_axis.tuser_out_port      != OUT_PORT)   ||
                       (s_axis.tuser_out_vport     != OUT_PORT);
`else
    logic unused_tuser;
    assign unused_tuser = ^{s_axis.tuser_packet_length, s_axis.tuser_in_port,
                            s_axis.tuser_in_vport, s_axis.tuser_out_port,
                            s_axis.tuser_out_vport, IN_PORT, OUT_PORT, PACKET_LEN};
    assign tuser_bad = 1'b0;
`endif

    // Any accepted tlast restarts the beat count so the checker realigns per frame.
    always_comb begin
        exp_data  = beat_data(rx_seq_q, rx_beat_q);
        exp_keep  = expected_keep(rx_beat_q, LAST_BEAT, LAST_KEEP);
        exp_last  = (rx_beat_q == LAST_BEAT);
        accept    = s_axis.tvalid && ready_q;
        bad       = (s_axis.tdata != exp_data) || (s_axis.tkeep != exp_keep) ||
                    (s_axis.tlast != exp_last) || tuser_bad;
        rx_seq_d  = rx_seq_q;
        rx_beat_d = rx_beat_q;
        err_d     = err_q;
        if (accept) begin
            if (s_axis.tlast) begin
                rx_beat_d = 8'd0;
                rx_seq_d  = rx_seq_q + 16'd1;
            end else begin
                rx_beat_d = rx_beat_q + 8'd1;
            end
            if (bad && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_seq_q  <= '0;
            rx_beat_q <= '0;
            err_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            rx_seq_q  <= rx_seq_d;
            rx_beat_q <= rx_beat_d;
            err_q     <= err_d;
            ready_q   <= 1'b1;
        end
    end

    assign s_axis.tready = ready_q;
    assign error_count   = err_q;

endmodule

// File: rtl/frame_gen_and_check.sv
// Deterministic AXI-Stream frame generator plus loopback checker for
// interconnect bring-up. Optional tuser checking: FRAME_GEN_TUSER_CHECK_EN.
module frame_gen_and_check
    import frame_gen_and_check_pkg::*;
#(
    parameter int               FRAME_BEATS = 4,
    parameter logic [KEEP_W-1:0] LAST_KEEP  = 32'hFFFF_FFFF,
    parameter logic [2:0]       IN_PORT     = 3'd0,
    parameter logic [7:0]       OUT_PORT    = 8'h01,
    parameter int               IDLE_CYCLES = 0
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,
    output logic [7:0]            error_count,
    frame_gen_and_check_if.master m_axis,
    frame_gen_and_check_if.slave  s_axis
);

    localparam logic [7:0]       LAST_BEAT  = 8'(FRAME_BEATS - 1);
    localparam logic [LEN_W-1:0] PACKET_LEN = LEN_W'((FRAME_BEATS - 1) * 32 + keep_popcount(LAST_KEEP));

    gen_state_e        state_q, state_d;
    logic [15:0]       tx_seq_q, tx_seq_d;
    logic [7:0]        tx_beat_q, tx_beat_d;
    logic [15:0]       idle_cnt_q, idle_cnt_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic [LEN_W-1:0]  plen_q, plen_d;
    logic              load;
    logic [15:0]       load_seq, next_seq;
    logic [7:0]        load_beat, next_beat;

    // tx_seq/tx_beat name the beat on the outputs; a load fetches a fresh beat.
    always_comb begin
        state_d    = state_q;
        tx_seq_d   = tx_seq_q;
        tx_beat_d  = tx_beat_q;
        idle_cnt_d = idle_cnt_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        plen_d     = PACKET_LEN;
        load       = 1'b0;
        load_seq   = tx_seq_q;
        load_beat  = tx_beat_q;
        next_seq   = tlast_q ? tx_seq_q + 16'd1 : tx_seq_q;
        next_beat  = tlast_q ? 8'd0 : tx_beat_q + 8'd1;
        case (state_q)
            GEN_SEND: begin
                if (!tvalid_q) begin
                    load = 1'b1;
                end else if (m_axis.tready) begin
                    tx_seq_d  = next_seq;
                    tx_beat_d = next_beat;
                    if (tlast_q && (IDLE_CYCLES > 0)) begin
                        state_d    = GEN_IDLE;
                        tvalid_d   = 1'b0;
                        idle_cnt_d = 16'(IDLE_CYCLES - 1);
                    end else begin
                        load      = 1'b1;
                        load_seq  = next_seq;
                        load_beat = next_beat;
                    end
                end
            end
            GEN_IDLE: begin
                if (idle_cnt_q == 16'd0) begin
                    state_d = GEN_SEND;
                    load    = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q - 16'd1;
                end
            end
            default: state_d = GEN_SEND;
        endcase
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = beat_data(load_seq, load_beat);
            tkeep_d  = expected_keep(load_beat, LAST_BEAT, LAST_KEEP);
            tlast_d  = (load_beat == LAST_BEAT);
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= GEN_SEND;
            tx_seq_q   <= '0;
            tx_beat_q  <= '0;
            idle_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            plen_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_seq_q   <= tx_seq_d;
            tx_beat_q  <= tx_beat_d;
            idle_cnt_q <= idle_cnt_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            plen_q     <= plen_d;
        end
    end

    assign m_axis.tvalid              = tvalid_q;
    assign m_axis.tlast               = tlast_q;
    assign m_axis.tdata               = tdata_q;
    assign m_axis.tkeep               = tkeep_q;
    assign m_axis.tuser_packet_length = plen_q;
    assign m_axis.tuser_in_port       = IN_PORT;
    assign m_axis.tuser_in_vport      = IN_PORT;
    assign m_axis.tuser_out_port      = OUT_PORT;
    assign m_axis.tuser_out_vport     = OUT_PORT;

    frame_checker #(
        .FRAME_BEATS (FRAME_BEATS),
        .LAST_KEEP   (LAST_KEEP),
        .IN_PORT     (IN_PORT),
        .OUT_PORT    (OUT_PORT),
        .PACKET_LEN  (PACKET_LEN)
    ) u_checker (
        .clk         (axi_aclk),
        .rst         (axi_reset),
        .s_axis      (s_axis),
        .error_count (error_count)
    );

endmodule

// File: tb/tb_frame_gen_and_check.sv
// Directed bench for frame_gen_and_check: registered loopback with optional
// corruption, stalls, a dropped tlast, zero data and a mid-frame reset.
module tb_frame_gen_and_check;
    import frame_gen_and_check_pkg::*;

    localparam logic [255:0] FIRST_BEAT =
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;

    logic       axi_aclk = 1'b0;
    logic       axi_reset;
    logic [7:0] error_count;
    int         checks   = 0;
    int         failures = 0;
    logic [15:0] exp_seq;
    int          exp_beat;

    frame_gen_and_check_if m_if ();
    frame_gen_and_check_if s_if ();

    frame_gen_and_check dut (
        .axi_aclk    (axi_aclk),
        .axi_reset   (axi_reset),
        .error_count (error_count),
        .m_axis      (m_if),
        .s_axis      (s_if)
    );

    always #5 axi_aclk = ~axi_aclk;

    function automatic logic [255:0] model_data(input logic [15:0] seq, input int beat);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = {seq, 8'(beat), 8'(i)};
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_tvalid", m_if.tvalid, 1'b0);
        checkOutput("rst_tdata", m_if.tdata, 256'h0);
        checkOutput("rst_tkeep", m_if.tkeep, 32'h0);
        checkOutput("rst_tlast", m_if.tlast, 1'b0);
        checkOutput("rst_plen", m_if.tuser_packet_length, 14'd0);
        checkOutput("rst_s_tready", s_if.tready, 1'b0);
        checkOutput("rst_error_count", error_count, 8'd0);
    endtask

    task automatic doReset();
        axi_reset = 1'b1;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser_packet_length = '0;
        s_if.tuser_in_port   = '0;
        s_if.tuser_in_vport  = '0;
        s_if.tuser_out_port  = '0;
        s_if.tuser_out_vport = '0;
        exp_seq  = 16'd0;
        exp_beat = 0;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        checkResetState();
        axi_reset = 1'b0;
    endtask

    task automatic checkFirstBeat();
        @(negedge axi_aclk);
        checkOutput("first_tvalid", m_if.tvalid, 1'b1);
        checkOutput("first_lane0", m_if.tdata[31:0], 32'h0000_0000);
        checkOutput("first_tdata", m_if.tdata, FIRST_BEAT);
        checkOutput("first_tkeep", m_if.tkeep, 32'hFFFF_FFFF);
        checkOutput("first_tlast", m_if.tlast, 1'b0);
        checkOutput("first_plen", m_if.tuser_packet_length, 14'd128);
        checkOutput("first_s_tready", s_if.tready, 1'b1);
    endtask

    // mode: 0 clean loopback, 1 corrupt every 256 cycles, 2 random tready,
    // 3 drop tlast of frame 2, 4 constant-zero data on the slave side
    task automatic applyStimulus(input int cycles, input int mode);
        logic         prev_stall;
        logic [255:0] snap_data;
        logic [31:0]  snap_keep;
        logic         snap_last;
        logic         hs;
        logic         pend_valid;
        logic [255:0] pend_data;
        logic [31:0]  pend_keep;
        logic         pend_last;
        prev_stall = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge axi_aclk);
            if (prev_stall) begin
                checkOutput("stall_tdata", m_if.tdata, snap_data);
                checkOutput("stall_ctrl", {m_if.tvalid, m_if.tlast, m_if.tkeep},
                            {1'b1, snap_last, snap_keep});
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            snap_data  = m_if.tdata;
            snap_keep  = m_if.tkeep;
            snap_last  = m_if.tlast;
            hs         = m_if.tvalid && m_if.tready;
            pend_valid = 1'b0;
            pend_data  = m_if.tdata;
            pend_keep  = m_if.tkeep;
            pend_last  = m_if.tlast;
            if (hs) begin
                checkOutput("gen_tdata", m_if.tdata, model_data(exp_seq, exp_beat));
                checkOutput("gen_ctrl", {m_if.tlast, m_if.tkeep}, {exp_beat == 3, 32'hFFFF_FFFF});
                pend_valid = 1'b1;
                if (mode == 1 && (i % 256) == 128) pend_data = 256'hAFFEDEAD;
                if (mode == 3 && exp_seq == 16'd2 && exp_beat == 3) pend_last = 1'b0;
                if (exp_beat == 3) begin
                    exp_beat = 0;
                    exp_seq++;
                end else begin
                    exp_beat++;
                end
            end
            if (mode == 4) begin
                pend_valid = 1'b1;
                pend_data  = '0;
                pend_keep  = '1;
                pend_last  = 1'b0;
            end
            @(posedge axi_aclk);
            #1;
            s_if.tvalid = pend_valid;
            s_if.tdata  = pend_data;
            s_if.tkeep  = pend_keep;
            s_if.tlast  = pend_last;
            s_if.tuser_packet_length = m_if.tuser_packet_length;
            s_if.tuser_in_port   = m_if.tuser_in_port;
            s_if.tuser_in_vport  = m_if.tuser_in_vport;
            s_if.tuser_out_port  = m_if.tuser_out_port;
            s_if.tuser_out_vport = m_if.tuser_out_vport;
            m_if.tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        m_if.tready = 1'b0;
        @(negedge axi_aclk);
        @(posedge axi_aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        doReset();
        checkFirstBeat();

        applyStimulus(1000, 0);
        checkOutput("loop_errors", error_count, 8'd0);
        checkOutput("loop_tx_seq", m_if.tdata[31:16], 16'd249);
        checkOutput("loop_tx_beat", m_if.tdata[15:8], 8'd3);
        checkOutput("loop_tlast", m_if.tlast, 1'b1);

        applyStimulus(1024, 1);
        checkOutput("corrupt_errors", error_count, 8'd4);

        applyStimulus(600, 2);
        checkOutput("stall_errors", error_count, 8'd4);

        doReset();
        checkFirstBeat();
        applyStimulus(13, 3);
        checkOutput("drop_tlast_errors", error_count, 8'd1);
        applyStimulus(5, 0);
        checkOutput("after_drop_errors", error_count, 8'd5);

        doReset();
        checkFirstBeat();
        applyStimulus(254, 4);
        checkOutput("zero_254", error_count, 8'd254);
        applyStimulus(1, 4);
        checkOutput("zero_255", error_count, 8'd255);
        applyStimulus(45, 4);
        checkOutput("zero_saturated", error_count, 8'd255);

        checkOutput("pre_reset_beat", m_if.tdata[15:8], 8'd1);
        @(negedge axi_aclk);
        #2;
        axi_reset = 1'b1;
        #1;
        checkResetState();
        doReset();
        checkFirstBeat();
        applyStimulus(100, 0);
        checkOutput("post_reset_errors", error_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_gen_and_check.md
# frame_gen_and_check

Self-test block for the 256-bit AXI-Stream interconnect datapath. It generates a continuous stream of deterministic frames on its master port and checks the frames that come back on its slave port, normally after a loopback through the path under test. Every mismatching beat increments a saturating error counter. It serves as a built-in traffic source and sink for bring-up and regression of interconnect stages.

## Interface
Parameters:
- FRAME_BEATS, 4: beats per frame (2..255).
- LAST_KEEP, 32'hFFFF_FFFF: tkeep on the last beat; all other beats use all-ones.
- IN_PORT, 3'd0: constant tuser_in_port and tuser_in_vport value.
- OUT_PORT, 8'h01: constant tuser_out_port and tuser_out_vport value.
- IDLE_CYCLES, 0: idle cycles (tvalid low) inserted after each generated frame.

Ports:
- axi_aclk  in  1  sole clock.
- axi_reset  in  1  asynchronous, active-high reset.
- error_count  out  8  count of bad beats received; saturates at 255.
- m_axis_tdata / tkeep  out  256 / 32  generated data / byte enables.
- m_axis_tuser_packet_length  out  14  frame length in bytes.
- m_axis_tuser_in_port / out_port / in_vport / out_vport  out  3/8/3/8  constant routing fields.
- m_axis_tvalid, m_axis_tlast  out  1  handshake and end of frame.
- m_axis_tready  in  1  downstream ready.
- s_axis_* (tdata, tkeep, tuser fields, tvalid, tlast)  in  same widths as m_axis_*  returned stream.
- s_axis_tready  out  1  checker ready.

## Operation
- Generator state: 16-bit tx_seq, 8-bit tx_beat, and an idle counter. States are SEND and IDLE.
- Beat content: lane i (i = 0..7, bits 32i+31:32i) = {seq[15:0], beat[7:0], i[7:0]}.
- tkeep = LAST_KEEP when beat == FRAME_BEATS-1, otherwise all-ones.
- tlast = (beat == FRAME_BEATS-1).
- packet_length = (FRAME_BEATS-1)*32 + popcount(LAST_KEEP).
- On m_axis_tvalid & m_axis_tready, tx_beat advances. After tlast, tx_beat wraps to 0, tx_seq increments (wrapping 0xFFFF to 0), and the generator enters IDLE for IDLE_CYCLES cycles. IDLE is skipped when IDLE_CYCLES = 0.
- Outputs are held stable while tvalid is high and tready is low (AXI-S rule).
- Checker: s_axis_tready is constant 1 outside reset. It keeps its own rx_seq and rx_beat and builds the expected beat with the same formula.
- An accepted beat is bad if tdata, tkeep or tlast differs from expected. Each bad beat adds exactly 1 to error_count.
- On every accepted beat, rx_beat advances. On every accepted tlast (expected or not), rx_beat goes to 0 and rx_seq increments, so the checker resynchronizes at frame boundaries.
- error_count saturates at 255 and never wraps.

## Timing
- Reset values: m_axis_tvalid = 0, tdata = 0, tkeep = 0, tlast = 0, packet_length = 0, s_axis_tready = 0, error_count = 0.
- Reset also clears tx_seq, tx_beat, rx_seq and rx_beat.
- Reset asserted mid-frame aborts the frame. After release, both generator and checker restart at seq 0, beat 0.
- m_axis_tvalid rises on the first clock edge after reset deasserts. All master outputs are registered.
- error_count updates on the clock edge that accepts the bad beat, so it is visible one cycle after the beat is presented.
- A beat presented with tvalid high while s_axis_tready is low (during reset) is neither counted nor checked.

## Configuration
- FRAME_GEN_TUSER_CHECK_EN defined: a beat is also bad if any s_axis_tuser field differs from the constant generated value.
- FRAME_GEN_TUSER_CHECK_EN undefined: tuser inputs are ignored.

## Structure
- Package frame_gen_and_check_pkg holds:
  - data, keep and tuser width constants;
  - the beat-pattern function (seq, beat, lane → 32-bit word);
  - the expected-keep function.
- The generator and the checker share this function.
- One sub-module, frame_checker, contains the receive counters, the comparison and the saturating error counter.

## Test plan
- Direct loopback (m to s, registered one stage), tready = 1, FRAME_BEATS = 4, 1000 cycles → error_count stays 0, and tx_seq reaches 250 (±1 for the beat in flight).
- Loopback, but replace one beat's tdata with 256'hAFFEDEAD every 256 cycles, over 1024 cycles → error_count = 4.
- m_axis_tready toggled randomly, loopback gated by handshake → m_axis outputs stable whenever stalled, error_count = 0.
- Drop one tlast in loopback → exactly 1 error at the dropped tlast position. The error count for the following frame is the number of mismatching beats there; it then returns to 0 errors once the next tlast resynchronizes the checker.
- Feed constant-zero tdata for 300 valid beats → error_count = 255 (saturated).
- Assert axi_reset mid-frame → all outputs reach their reset values asynchronously, and the first beat after release has lane 0 = 32'h0000_0000.
